// File: rtl/mem_refill_arbiter.sv
// Round-robin line sequencer: shares one word-wide memory port between the instruction
// cache (I) and the data cache (D), splitting each granted line into LINE_WORDS beats.
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_i,
    input  logic [ADDR_W-1:0]             i_addr_i,
    output logic                          o_rvalid_i,
    output logic                          o_done_i,
    input  logic                          i_req_d,
    input  logic                          i_we_d,
    input  logic [ADDR_W-1:0]             i_addr_d,
    input  logic [DATA_W-1:0]             i_wdata_d,
    output logic                          o_wready_d,
    output logic                          o_rvalid_d,
    output logic                          o_done_d,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] o_rbeat,
    output logic [$clog2(LINE_WORDS)-1:0] o_beat,
    output logic                          o_busy,
    output logic                          o_owner,
    output logic                          o_mem_req,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic                          i_mem_ready,
    input  logic                          i_mem_rvalid,
    input  logic [DATA_W-1:0]             i_mem_rdata
);

    localparam int BW = $clog2(LINE_WORDS);
    localparam int CW = BW + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner;      // also the round-robin pointer: last requester served
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     rtn_cnt;
    logic              rvalid_q;
    logic              grant_d;
    logic              accept;
    logic              rtn_take;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        grant_d   = i_req_d && (!i_req_i || !owner);
        o_mem_req = (state == READ || state == WRITE) && !issue_cnt[BW];
        accept    = o_mem_req && i_mem_ready;
        rtn_take  = (state == READ) && i_mem_rvalid && !rtn_cnt[BW];

        case (state)
            IDLE: begin
                if (i_req_i || i_req_d)
                    state_nxt = (grant_d && i_we_d) ? WRITE : READ;
            end
            READ: begin
                if (rtn_take && rtn_cnt == CW'(LINE_WORDS - 1))
                    state_nxt = DONE;
            end
            WRITE: begin
                if (accept && issue_cnt == CW'(LINE_WORDS - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line base keeps the upper bits only, so the beat offset is OR-ed in and never carries.
    assign o_mem_addr  = base | ADDR_W'({issue_cnt[BW-1:0], 2'b00});
    assign o_mem_we    = (state == WRITE);
    assign o_mem_wdata = i_wdata_d;
    assign o_wready_d  = o_mem_we && accept;
    assign o_beat      = issue_cnt[BW-1:0];
    assign o_busy      = (state != IDLE);
    assign o_owner     = owner;
    assign o_rvalid_i  = rvalid_q && !owner;
    assign o_rvalid_d  = rvalid_q && owner;
    assign o_done_i    = (state == DONE) && !owner;
    assign o_done_d    = (state == DONE) && owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            rtn_cnt   <= '0;
            rvalid_q  <= 1'b0;
            o_rdata   <= '0;
            o_rbeat   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rvalid_q <= 1'b0;
            if (state == IDLE) begin
                issue_cnt <= '0;
                rtn_cnt   <= '0;
                if (i_req_i || i_req_d) begin
                    owner <= grant_d;
                    base  <= (grant_d ? i_addr_d : i_addr_i) & ~LINE_MASK;
                end
            end else begin
                if (accept)
                    issue_cnt <= issue_cnt + CW'(1);
                if (rtn_take) begin
                    o_rdata  <= i_mem_rdata;
                    o_rbeat  <= rtn_cnt[BW-1:0];
                    rvalid_q <= 1'b1;
                    rtn_cnt  <= rtn_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Sequences cache-line refills and write-backs to a single shared backing-memory port for two requesters: the instruction cache (port I) and the data cache `sa_cache` (port D).
- Sits between the two caches' miss interfaces and the memory.
- Arbitrates round-robin and breaks each line into LINE_WORDS single-word memory beats.
- Returns read words with their beat index and signals line completion.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width
LINE_WORDS, 16, words per line (64 B line, offset bits [5:0]); power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_req_i  in  1  icache line read request; held until o_done_i
i_addr_i  in  ADDR_W  icache miss address
o_rvalid_i  out  1  o_rdata/o_rbeat valid for icache
o_done_i  out  1  icache line complete, 1-cycle pulse
i_req_d  in  1  dcache request; held until o_done_d
i_we_d  in  1  1 = line write-back, 0 = line read
i_addr_d  in  ADDR_W  dcache address
i_wdata_d  in  DATA_W  write word for beat o_beat
o_wready_d  out  1  i_wdata_d consumed this cycle
o_rvalid_d  out  1  o_rdata/o_rbeat valid for dcache
o_done_d  out  1  dcache line complete, 1-cycle pulse
o_rdata  out  DATA_W  registered read word (shared)
o_rbeat  out  log2(LINE_WORDS)  beat index of o_rdata
o_beat  out  log2(LINE_WORDS)  index of beat currently being issued
o_busy  out  1  transaction in progress
o_owner  out  1  0 = I, 1 = D; valid while o_busy
o_mem_req  out  1  memory command valid
o_mem_we  out  1  command is write
o_mem_addr  out  ADDR_W  word address of command
o_mem_wdata  out  DATA_W  write data (= i_wdata_d)
i_mem_ready  in  1  memory accepts command this cycle
i_mem_rvalid  in  1  read return valid (returns in issue order)
i_mem_rdata  in  DATA_W  read return data

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; rr pointer = I (so D wins the first tie).
  - Outputs 0: o_mem_req, o_busy, o_rvalid_*, o_done_*, o_rdata, o_rbeat, o_beat, o_owner.
- States: IDLE, READ, WRITE, DONE.
- IDLE, arbitration: if exactly one requester is asserted, grant it. If both are asserted, grant the one not last served.
  - Next cycle: latch owner, we (0 for I), base = addr with low log2(LINE_WORDS*4) bits cleared; rr pointer := owner.
  - Enter READ or WRITE; o_busy=1.
- Issue, READ and WRITE:
  - o_mem_req=1 while issue_cnt < LINE_WORDS.
  - o_mem_addr = base + 4*issue_cnt; o_beat = issue_cnt[low bits].
  - A beat is accepted when o_mem_req && i_mem_ready; issue_cnt++ on accept.
  - o_mem_req holds with a stable addr/we while i_mem_ready=0.
- WRITE:
  - o_mem_we=1; o_mem_wdata = i_wdata_d (combinational).
  - o_wready_d = o_mem_req && i_mem_ready.
  - On the final accept, go to DONE; o_done_d pulses on the DONE cycle.
- READ:
  - Issue and return proceed concurrently; rtn_cnt counts i_mem_rvalid.
  - Each return registers o_rdata=i_mem_rdata and o_rbeat=rtn_cnt, and asserts the owner's o_rvalid_x the following cycle.
  - On the LINE_WORDS-th return go to DONE; the owner's o_done_x is asserted in the same cycle as the final o_rvalid_x.
- DONE: one cycle; o_busy=0 next cycle; return to IDLE. Re-arbitration happens in IDLE, so there is a minimum of 1 idle cycle between transactions.
- i_mem_rvalid outside READ, or once rtn_cnt=LINE_WORDS: ignored, no output.
- Request changes while busy: ignored until IDLE. Requesters must not drop req early; behaviour if they do is undefined.
- Counters are log2(LINE_WORDS)+1 bits wide; base+offset never carries past the line boundary.
- Reset mid-burst: immediate abort, all outputs to reset values; the memory side must tolerate the dropped command.

Test Plan:
1. I read, addr 0x0000_1234, ready=1, memory latency 2.
   - Expect mem addrs 0x1200..0x123C on 16 consecutive cycles.
   - Expect 16 o_rvalid_i with o_rbeat 0..15; o_done_i with beat 15; o_rvalid_d is never asserted.
2. I and D reads asserted in the same cycle, both held.
   - Expect D served first (o_owner=1), then I, with one idle cycle between o_done_d and the next o_mem_req.
   - A second D request during I's service waits until I completes.
3. D write-back, addr 0x0000_8040, i_wdata_d = 0xA000_0000 + o_beat, i_mem_ready toggling 1,0,1,0.
   - Expect 16 write beats, wdata 0xA000_0000..0xA000_000F at addrs 0x8040..0x807C.
   - Expect addr held stable on ready=0 cycles; o_done_d one cycle after the last accept.
4. Read with i_mem_ready=1 but returns delayed by 5 cycles.
   - Expect issue to finish before the returns; o_done only after the 16th return.
   - Expect a stray i_mem_rvalid injected in IDLE to produce no o_rvalid_*.
5. rst pulled low after beat 7 of a D read.
   - Expect o_mem_req, o_busy and all valid/done outputs at 0 immediately.
   - After rst releases with I requesting, I is granted and starts at beat 0.
